// File: rtl/alu_seq_display.sv
// Sequential signed ALU with accumulator, optional shift-add multiplier and registered
// seven-segment display code. Define ALU_MUL_EN to build the multi-cycle multiplier (opcode 100).
module alu_seq_display #(
    parameter int NBITS = 4
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] result,
    output logic             overflow,
    output logic             zero,
    output logic             neg,
    output logic [7:0]       seg
);

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`else
    typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif

    state_t           state, next_state;
    logic [NBITS-1:0] acc;
    logic [NBITS:0]   a_ext, b_ext, acc_ext, wide;
    logic [NBITS-1:0] sc_result, new_result;
    logic             sc_ovf, new_ovf, load;

    // Seven-segment code from a result; magnitude is unsigned so the most negative value survives.
    function automatic logic [7:0] seg_code(input logic [NBITS-1:0] value, input logic ovf);
        logic [NBITS-1:0] mag;
        logic [7:0]       code;
        mag = value[NBITS-1] ? (~value + NBITS'(1)) : value;
        case (32'(mag))
            32'd0:   code = 8'h3F;
            32'd1:   code = 8'h06;
            32'd2:   code = 8'h5B;
            32'd3:   code = 8'h4F;
            32'd4:   code = 8'h66;
            32'd5:   code = 8'h6D;
            32'd6:   code = 8'h7D;
            32'd7:   code = 8'h07;
            32'd8:   code = 8'h7F;
            32'd9:   code = 8'h6F;
            default: code = 8'h40;
        endcase
        if (ovf)
            code = 8'hBF;
        else if (value[NBITS-1] && code != 8'h40)
            code = code | 8'h80;
        return code;
    endfunction

    // Single-cycle datapath; arithmetic is done one bit wider so overflow is the top-two-bit mismatch.
    always_comb begin
        a_ext     = {a[NBITS-1], a};
        b_ext     = {b[NBITS-1], b};
        acc_ext   = {acc[NBITS-1], acc};
        wide      = '0;
        sc_result = '0;
        sc_ovf    = 1'b0;
        case (op)
            3'b000: begin
                wide      = a_ext + b_ext;
                sc_result = wide[NBITS-1:0];
                sc_ovf    = wide[NBITS] ^ wide[NBITS-1];
            end
            3'b001: begin
                wide      = a_ext - b_ext;
                sc_result = wide[NBITS-1:0];
                sc_ovf    = wide[NBITS] ^ wide[NBITS-1];
            end
            3'b010: sc_result = a & b;
            3'b011: sc_result = a | b;
            3'b100: begin
`ifndef ALU_MUL_EN
                sc_ovf = 1'b1;
`endif
            end
            3'b101: begin
                wide      = acc_ext + a_ext;
                sc_result = wide[NBITS-1:0];
                sc_ovf    = wide[NBITS] ^ wide[NBITS-1];
            end
            3'b110: sc_result = '0;
            3'b111: sc_result = a ^ b;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(NBITS + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(NBITS);

    logic [2*NBITS-1:0] mcand, prod, prod_step, prod_signed;
    logic [NBITS-1:0]   mplier, mag_a, mag_b;
    logic [CW-1:0]      count;
    logic               prod_neg, mul_ovf;

    // Product fits in NBITS when its top NBITS+1 bits are all copies of the sign.
    always_comb begin
        mag_a       = a[NBITS-1] ? (~a + NBITS'(1)) : a;
        mag_b       = b[NBITS-1] ? (~b + NBITS'(1)) : b;
        prod_step   = prod + (mplier[0] ? mcand : '0);
        prod_signed = prod_neg ? (~prod_step + (2*NBITS)'(1)) : prod_step;
        mul_ovf     = !((&prod_signed[2*NBITS-1:NBITS-1]) || !(|prod_signed[2*NBITS-1:NBITS-1]));
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            count    <= '0;
            prod_neg <= 1'b0;
        end else if (state == IDLE && start && op == 3'b100) begin
            mcand    <= {{NBITS{1'b0}}, mag_a};
            mplier   <= mag_b;
            prod     <= '0;
            count    <= COUNT_INIT;
            prod_neg <= a[NBITS-1] ^ b[NBITS-1];
        end else if (state == MUL) begin
            prod   <= prod_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
        end
    end
`endif

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        new_result = sc_result;
        new_ovf    = sc_ovf;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef ALU_MUL_EN
                    if (op == 3'b100) begin
                        next_state = MUL;
                    end else begin
                        next_state = DONE;
                        load       = 1'b1;
                    end
`else
                    next_state = DONE;
                    load       = 1'b1;
`endif
                end
            end
`ifdef ALU_MUL_EN
            MUL: begin
                if (count == CW'(1)) begin
                    next_state = DONE;
                    load       = 1'b1;
                    new_result = prod_signed[NBITS-1:0];
                    new_ovf    = mul_ovf;
                end
            end
`endif
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The accumulator only moves on an accepted 101/110 request.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (state == IDLE && start) begin
            if (op == 3'b101)
                acc <= sc_result;
            else if (op == 3'b110)
                acc <= '0;
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            result   <= '0;
            overflow <= 1'b0;
            zero     <= 1'b1;
            neg      <= 1'b0;
            seg      <= 8'h3F;
        end else if (load) begin
            result   <= new_result;
            overflow <= new_ovf;
            zero     <= (new_result == '0);
            neg      <= new_result[NBITS-1];
            seg      <= seg_code(new_result, new_ovf);
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_alu_seq_display.sv
// Self-checking bench for alu_seq_display at NBITS=4: directed vector table, handshake corner
// sequences and randomized operations against an integer-arithmetic reference model.
module tb_alu_seq_display;

    localparam int NBITS = 4;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clk_2 = 1'b0;
    logic       reset, start;
    logic [2:0] op;
    logic [3:0] a, b;
    logic       busy, done, overflow, zero, neg;
    logic [3:0] result;
    logic [7:0] seg;

    int         tests = 0;
    int         fails = 0;
    int         acc_model = 0;
    logic [3:0] last_res = 4'd0;
    logic [7:0] digit_codes [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                     8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       ovf;
        logic [7:0] seg;
    } vec_t;
    vec_t vecs [16];

    alu_seq_display #(.NBITS(NBITS)) dut (
        .clk_2(clk_2), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .overflow(overflow),
        .zero(zero), .neg(neg), .seg(seg)
    );

    always #5 clk_2 = ~clk_2;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference model: plain signed integer arithmetic with range checks.
    function automatic void model(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                                  output logic [3:0] r, output logic v);
        int sa, sb, t;
        sa = $signed(x);
        sb = $signed(y);
        t  = 0;
        r  = 4'd0;
        v  = 1'b0;
        case (o)
            3'd0: t = sa + sb;
            3'd1: t = sa - sb;
            3'd4: t = MUL_EN ? sa * sb : 0;
            3'd5: t = acc_model + sa;
            default: t = 0;
        endcase
        case (o)
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd7: r = x ^ y;
            3'd6: begin r = 4'd0; acc_model = 0; end
            3'd4: begin
                if (MUL_EN) begin
                    r = 4'(t);
                    v = (t < -8 || t > 7);
                end else begin
                    r = 4'd0;
                    v = 1'b1;
                end
            end
            default: begin
                r = 4'(t);
                v = (t < -8 || t > 7);
                if (o == 3'd5) acc_model = int'($signed(r));
            end
        endcase
    endfunction

    function automatic logic [7:0] seg_model(input logic [3:0] r, input logic v);
        int val, mag;
        if (v) return 8'hBF;
        val = $signed(r);
        mag = (val < 0) ? -val : val;
        if (mag <= 9) return digit_codes[mag] | ((val < 0) ? 8'h80 : 8'h00);
        return 8'h40;
    endfunction

    // Issues one request and waits (bounded) for done; result must hold its old value meanwhile.
    task automatic applyStimulus(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y, output int lat);
        @(negedge clk_2);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk_2);
        #1;
        start = 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
        op = 3'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            checkOutput("held_result", result, last_res);
            @(posedge clk_2);
            #1;
            lat++;
        end
        if (lat >= 40) checkOutput("done_timeout", done, 1);
    endtask

    task automatic runOp(input string name, input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                         input logic [3:0] er, input logic ev, input logic [7:0] es, input int elat);
        int lat;
        applyStimulus(o, x, y, lat);
        checkOutput({name, "_latency"}, lat, elat);
        checkOutput({name, "_result"}, result, er);
        checkOutput({name, "_overflow"}, overflow, ev);
        checkOutput({name, "_zero"}, zero, (er == 4'd0));
        checkOutput({name, "_neg"}, neg, er[3]);
        checkOutput({name, "_seg"}, seg, es);
        checkOutput({name, "_busy"}, busy, 1);
        last_res = er;
        @(posedge clk_2);
        #1;
        checkOutput({name, "_done_clear"}, {busy, done}, 2'b00);
    endtask

    task automatic runModelOp(input string name, input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
        logic [3:0] r;
        logic       v;
        model(o, x, y, r, v);
        runOp(name, o, x, y, r, v, seg_model(r, v), (o == 3'd4 && MUL_EN) ? NBITS : 0);
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, "_result"}, result, 0);
        checkOutput({name, "_flags"}, {overflow, zero, neg, busy, done}, 5'b01000);
        checkOutput({name, "_seg"}, seg, 8'h3F);
    endtask

    initial begin
        int pulses, lat;
        logic [3:0] r;
        logic       v;

        vecs[0]  = '{3'd0, 4'h3, 4'h4, 4'h7, 1'b0, 8'h07};
        vecs[1]  = '{3'd0, 4'h5, 4'h4, 4'h9, 1'b1, 8'hBF};
        vecs[2]  = '{3'd1, 4'hE, 4'h1, 4'hD, 1'b0, 8'hCF};
        vecs[3]  = '{3'd1, 4'h8, 4'h1, 4'h7, 1'b1, 8'hBF};
        vecs[4]  = '{3'd2, 4'hC, 4'h6, 4'h4, 1'b0, 8'h66};
        vecs[5]  = '{3'd3, 4'h1, 4'h2, 4'h3, 1'b0, 8'h4F};
        vecs[6]  = '{3'd7, 4'h5, 4'h5, 4'h0, 1'b0, 8'h3F};
        vecs[7]  = '{3'd7, 4'h6, 4'h3, 4'h5, 1'b0, 8'h6D};
        vecs[8]  = '{3'd0, 4'hF, 4'hF, 4'hE, 1'b0, 8'hDB};
        vecs[9]  = '{3'd0, 4'h8, 4'h8, 4'h0, 1'b1, 8'hBF};
        vecs[10] = '{3'd1, 4'h7, 4'h8, 4'hF, 1'b1, 8'hBF};
        vecs[11] = '{3'd6, 4'h0, 4'h0, 4'h0, 1'b0, 8'h3F};
        vecs[12] = '{3'd5, 4'h7, 4'h0, 4'h7, 1'b0, 8'h07};
        vecs[13] = '{3'd5, 4'h7, 4'h0, 4'hE, 1'b1, 8'hBF};
        vecs[14] = '{3'd5, 4'hF, 4'h0, 4'hD, 1'b0, 8'hCF};
        vecs[15] = '{3'd1, 4'h0, 4'h1, 4'hF, 1'b0, 8'h86};

        reset = 1'b1; start = 1'b0; op = 3'd0; a = 4'd0; b = 4'd0;
        repeat (2) @(negedge clk_2);
        reset = 1'b0;
        #1;
        checkResetValues("reset");

        for (int i = 0; i < 16; i++) begin
            model(vecs[i].op, vecs[i].a, vecs[i].b, r, v);
            runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].res, vecs[i].ovf, vecs[i].seg, 0);
        end

`ifdef ALU_MUL_EN
        runOp("mul_m2x3", 3'd4, 4'hE, 4'h3, 4'hA, 1'b0, 8'hFD, NBITS);
        runOp("mul_m3x3", 3'd4, 4'hD, 4'h3, 4'h7, 1'b1, 8'hBF, NBITS);
        runModelOp("mul_m8x1", 3'd4, 4'h8, 4'h1);
        runModelOp("mul_m8xm8", 3'd4, 4'h8, 4'h8);

        // A start pulse arriving mid-multiply must be dropped.
        @(negedge clk_2);
        op = 3'd4; a = 4'hE; b = 4'h3; start = 1'b1;
        @(negedge clk_2);
        op = 3'd0; a = 4'h1; b = 4'h1;
        @(negedge clk_2);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk_2);
            #1;
            lat++;
        end
        checkOutput("ignored_start_done", done, 1);
        checkOutput("ignored_start_result", result, 4'hA);
        checkOutput("ignored_start_ovf", overflow, 0);
        last_res = 4'hA;
        @(posedge clk_2);
        #1;
        checkOutput("ignored_start_idle", busy, 0);
`else
        runOp("op100_disabled", 3'd4, 4'h2, 4'h2, 4'h0, 1'b1, 8'hBF, 0);
`endif

        // Held start: single-cycle ops are accepted every second edge.
        @(negedge clk_2);
        op = 3'd0; a = 4'h1; b = 4'h1; start = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(posedge clk_2);
            #1;
            if (done) pulses++;
        end
        start = 1'b0;
        checkOutput("held_start_pulses", pulses, 3);
        checkOutput("held_start_result", result, 4'h2);
        last_res = 4'h2;

        // Asynchronous reset in the middle of an operation.
        @(negedge clk_2);
        op = MUL_EN ? 3'd4 : 3'd0; a = 4'h3; b = 4'h3; start = 1'b1;
        @(posedge clk_2);
        #1;
        start = 1'b0;
        @(posedge clk_2);
        #2;
        reset = 1'b1;
        #1;
        checkResetValues("midop_reset");
        @(negedge clk_2);
        reset = 1'b0;
        acc_model = 0;
        last_res = 4'd0;
        runModelOp("acc_after_reset", 3'd5, 4'h2, 4'h0);

        for (int i = 0; i < 60; i++) begin
            runModelOp($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
